accelerator_standard_lstm_matrix_feeder: RTL and testbench

Upstream feeder for the standard LSTM accelerator. It streams one SIZE_L x SIZE_X weight/state matrix (W, K, U, ...) from a word-addressed memory into the accelerator's matrix input port using the codebase's L/X enable handshake. It generates row-major memory addresses without a multiplier, handles one-cycle read latency, and paces each element on the accelerator's OUT_x_ENABLE requests. One instance is used per matrix input.

---
 rtl/accelerator_standard_lstm_matrix_feeder.sv | 134 +++++++++++++
 tb/tb_accelerator_standard_lstm_matrix_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_standard_lstm_matrix_feeder.sv
// rtl/accelerator_standard_lstm_matrix_feeder.sv - streams one SIZE_L x SIZE_X matrix from memory into the LSTM accelerator
module accelerator_standard_lstm_matrix_feeder #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  input  logic [DATA_SIZE-1:0] SIZE_X_IN,
  input  logic [DATA_SIZE-1:0] BASE_ADDRESS_IN,
  output logic                 MEMORY_READ,
  output logic [DATA_SIZE-1:0] MEMORY_ADDRESS,
  input  logic [DATA_SIZE-1:0] MEMORY_DATA,
  output logic                 W_IN_L_ENABLE,
  output logic                 W_IN_X_ENABLE,
  output logic [DATA_SIZE-1:0] W_IN,
  input  logic                 W_OUT_L_ENABLE,
  input  logic                 W_OUT_X_ENABLE
);

  // CONTROL_SIZE only keeps the parameter list aligned with the other feeders
  if (CONTROL_SIZE < 1) begin : g_bad_control_size
    $error("CONTROL_SIZE must be positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_WAIT} state_t;

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  state_t               state, state_next;
  logic [DATA_SIZE-1:0] size_l, size_x, i, j, row_base;
  logic [DATA_SIZE-1:0] size_l_next, size_x_next, i_next, j_next, row_base_next;
  logic [DATA_SIZE-1:0] addr_next, w_next;
  logic                 ready_next, read_next, l_next, x_next;
  logic                 last_col, last_row;

  // j/i reach their final index; only meaningful once sizes are latched nonzero
  assign last_col = (j == size_x - ONE);
  assign last_row = (i == size_l - ONE);

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  // next state plus next values of every registered output; the address is
  // computed one step ahead so MEMORY_READ/MEMORY_ADDRESS are valid in FETCH
  always_comb begin
    state_next    = state;
    size_l_next   = size_l;
    size_x_next   = size_x;
    i_next        = i;
    j_next        = j;
    row_base_next = row_base;
    addr_next     = MEMORY_ADDRESS;
    w_next        = W_IN;
    read_next     = 1'b0;
    l_next        = 1'b0;
    x_next        = 1'b0;
    case (state)
      S_IDLE: begin
        if (START && (SIZE_L_IN != '0) && (SIZE_X_IN != '0)) begin
          size_l_next   = SIZE_L_IN;
          size_x_next   = SIZE_X_IN;
          row_base_next = BASE_ADDRESS_IN;
          i_next        = '0;
          j_next        = '0;
          addr_next     = BASE_ADDRESS_IN;
          read_next     = 1'b1;
          state_next    = S_FETCH;
        end
      end
      S_FETCH: state_next = S_LATCH;
      S_LATCH: begin
        w_next     = MEMORY_DATA;
        x_next     = 1'b1;
        l_next     = (j == '0);
        state_next = (last_row && last_col) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (!last_col) begin
          if (W_OUT_X_ENABLE) begin
            j_next     = j + ONE;
            addr_next  = row_base + j + ONE;
            read_next  = 1'b1;
            state_next = S_FETCH;
          end
        end else if (W_OUT_L_ENABLE) begin
          j_next        = '0;
          i_next        = i + ONE;
          row_base_next = row_base + size_x;
          addr_next     = row_base + size_x;
          read_next     = 1'b1;
          state_next    = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
    ready_next = (state_next == S_IDLE);
  end

  // datapath and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY          <= 1'b0;
      MEMORY_READ    <= 1'b0;
      MEMORY_ADDRESS <= '0;
      W_IN_L_ENABLE  <= 1'b0;
      W_IN_X_ENABLE  <= 1'b0;
      W_IN           <= '0;
      size_l         <= '0;
      size_x         <= '0;
      i              <= '0;
      j              <= '0;
      row_base       <= '0;
    end else begin
      READY          <= ready_next;
      MEMORY_READ    <= read_next;
      MEMORY_ADDRESS <= addr_next;
      W_IN_L_ENABLE  <= l_next;
      W_IN_X_ENABLE  <= x_next;
      W_IN           <= w_next;
      size_l         <= size_l_next;
      size_x         <= size_x_next;
      i              <= i_next;
      j              <= j_next;
      row_base       <= row_base_next;
    end
  end

endmodule

// File: tb/tb_accelerator_standard_lstm_matrix_feeder.sv
// tb/tb_accelerator_standard_lstm_matrix_feeder.sv - scoreboard bench for the LSTM matrix feeder
module tb_accelerator_standard_lstm_matrix_feeder;

  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST, START, READY, MEMORY_READ;
  logic          W_IN_L_ENABLE, W_IN_X_ENABLE, W_OUT_L_ENABLE, W_OUT_X_ENABLE;
  logic [DW-1:0] SIZE_L_IN, SIZE_X_IN, BASE_ADDRESS_IN, MEMORY_ADDRESS, MEMORY_DATA, W_IN;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] obs_addr[$], exp_addr[$];
  logic [DW+1:0] obs_pulse[$], exp_pulse[$];
  int            obs_cyc[$];

  accelerator_standard_lstm_matrix_feeder #(.DATA_SIZE(DW), .CONTROL_SIZE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_L_IN(SIZE_L_IN), .SIZE_X_IN(SIZE_X_IN), .BASE_ADDRESS_IN(BASE_ADDRESS_IN),
    .MEMORY_READ(MEMORY_READ), .MEMORY_ADDRESS(MEMORY_ADDRESS), .MEMORY_DATA(MEMORY_DATA),
    .W_IN_L_ENABLE(W_IN_L_ENABLE), .W_IN_X_ENABLE(W_IN_X_ENABLE), .W_IN(W_IN),
    .W_OUT_L_ENABLE(W_OUT_L_ENABLE), .W_OUT_X_ENABLE(W_OUT_X_ENABLE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // memory with one-cycle read latency: mem[a] = a + 0x100
  always @(posedge CLK) if (MEMORY_READ) MEMORY_DATA <= MEMORY_ADDRESS + 64'h100;

  // monitor: record every fetch and every element pulse {data, l, ready}
  always @(negedge CLK) begin
    if (MEMORY_READ === 1'b1) obs_addr.push_back(MEMORY_ADDRESS);
    if (W_IN_X_ENABLE === 1'b1) begin
      obs_pulse.push_back({W_IN, W_IN_L_ENABLE, READY});
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_xfer(input logic [DW-1:0] l, input logic [DW-1:0] x, input logic [DW-1:0] base);
    @(posedge CLK);
    obs_addr.delete(); obs_pulse.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_pulse.delete();
    @(negedge CLK);
    SIZE_L_IN = l; SIZE_X_IN = x; BASE_ADDRESS_IN = base; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (W_IN_X_ENABLE === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic answer(input bit row, input int dly);
    repeat (dly) @(negedge CLK);
    if (row) W_OUT_L_ENABLE = 1'b1; else W_OUT_X_ENABLE = 1'b1;
    @(negedge CLK);
    W_OUT_L_ENABLE = 1'b0; W_OUT_X_ENABLE = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({READY, MEMORY_READ, W_IN_L_ENABLE, W_IN_X_ENABLE} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {READY, MEMORY_READ, W_IN_L_ENABLE, W_IN_X_ENABLE});
    end
    total++;
    if (MEMORY_ADDRESS !== '0 || W_IN !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%0h w=%0h want 0 0", MEMORY_ADDRESS, W_IN);
    end
    RST = 1'b0;
    #1;
    total++;
    if (READY !== 1'b0) begin bad++; $display("FAIL reset_ready_early: got %b want 0", READY); end
    @(negedge CLK);
    total++;
    if (READY !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", READY); end
    repeat (3) @(negedge CLK);
    total++;
    if (obs_addr.size() != 0 || obs_pulse.size() != 0) begin
      bad++; $display("FAIL reset_quiet: got reads=%0d pulses=%0d want 0 0", obs_addr.size(), obs_pulse.size());
    end
  endtask

  task automatic test_matrix_2x3();
    bit ok;
    logic [DW-1:0] ea, oa;
    logic [DW+1:0] ep, op;
    start_xfer(64'd2, 64'd3, 64'h10);
    SIZE_L_IN = 64'd7; SIZE_X_IN = 64'd9; BASE_ADDRESS_IN = 64'h999;
    for (int k = 0; k < 6; k++) begin
      exp_addr.push_back(64'h10 + DW'(k));
      exp_pulse.push_back({64'h110 + DW'(k), k % 3 == 0, k == 5});
    end
    for (int k = 0; k < 6; k++) begin
      wait_pulse(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL m2x3_timeout: got none want pulse %0d", k); end
      if (k < 5) answer(k == 2, 2);
    end
    repeat (4) @(negedge CLK);
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      total++;
      if (obs_addr.size() == 0) begin bad++; $display("FAIL m2x3_addr: got none want %0h", ea); end
      else begin
        oa = obs_addr.pop_front();
        if (oa !== ea) begin bad++; $display("FAIL m2x3_addr: got %0h want %0h", oa, ea); end
      end
    end
    while (exp_pulse.size() > 0) begin
      ep = exp_pulse.pop_front();
      total++;
      if (obs_pulse.size() == 0) begin bad++; $display("FAIL m2x3_pulse: got none want %0h", ep); end
      else begin
        op = obs_pulse.pop_front();
        if (op !== ep) begin bad++; $display("FAIL m2x3_pulse: got %0h want %0h", op, ep); end
      end
    end
    total++;
    if (obs_addr.size() != 0 || obs_pulse.size() != 0 || READY !== 1'b1) begin
      bad++; $display("FAIL m2x3_tail: got extra=%0d/%0d ready=%b want 0/0 1", obs_addr.size(), obs_pulse.size(), READY);
    end
  endtask

  task automatic test_wrong_request();
    bit ok;
    logic [DW-1:0] ea, oa;
    logic [DW+1:0] ep, op;
    start_xfer(64'd2, 64'd3, 64'h10);
    for (int k = 0; k < 6; k++) begin
      exp_addr.push_back(64'h10 + DW'(k));
      exp_pulse.push_back({64'h110 + DW'(k), k % 3 == 0, k == 5});
    end
    wait_pulse(ok);
    answer(1'b1, 2);
    repeat (4) @(negedge CLK);
    total++;
    if (obs_addr.size() != 1 || obs_pulse.size() != 1) begin
      bad++; $display("FAIL wrong_req_stall: got reads=%0d pulses=%0d want 1 1", obs_addr.size(), obs_pulse.size());
    end
    answer(1'b0, 0);
    for (int k = 1; k < 6; k++) begin
      wait_pulse(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL wrong_req_timeout: got none want pulse %0d", k); end
      if (k < 5) answer(k == 2, 1);
    end
    repeat (4) @(negedge CLK);
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      total++;
      if (obs_addr.size() == 0) begin bad++; $display("FAIL wrong_req_addr: got none want %0h", ea); end
      else begin
        oa = obs_addr.pop_front();
        if (oa !== ea) begin bad++; $display("FAIL wrong_req_addr: got %0h want %0h", oa, ea); end
      end
    end
    while (exp_pulse.size() > 0) begin
      ep = exp_pulse.pop_front();
      total++;
      if (obs_pulse.size() == 0) begin bad++; $display("FAIL wrong_req_pulse: got none want %0h", ep); end
      else begin
        op = obs_pulse.pop_front();
        if (op !== ep) begin bad++; $display("FAIL wrong_req_pulse: got %0h want %0h", op, ep); end
      end
    end
  endtask

  task automatic test_both_enables();
    logic [DW-1:0] ea, oa;
    logic [DW+1:0] ep, op;
    @(negedge CLK);
    W_OUT_X_ENABLE = 1'b1; W_OUT_L_ENABLE = 1'b1;
    start_xfer(64'd3, 64'd1, 64'h20);
    for (int k = 0; k < 3; k++) begin
      exp_addr.push_back(64'h20 + DW'(k));
      exp_pulse.push_back({64'h120 + DW'(k), 1'b1, k == 2});
    end
    repeat (20) @(negedge CLK);
    total++;
    if (obs_cyc.size() != 3) begin bad++; $display("FAIL both_3x1_count: got %0d want 3", obs_cyc.size()); end
    else for (int k = 1; k < 3; k++) begin
      total++;
      if (obs_cyc[k] - obs_cyc[k-1] != 3) begin
        bad++; $display("FAIL both_3x1_spacing: got %0d want 3", obs_cyc[k] - obs_cyc[k-1]);
      end
    end
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      total++;
      if (obs_addr.size() == 0) begin bad++; $display("FAIL both_3x1_addr: got none want %0h", ea); end
      else begin
        oa = obs_addr.pop_front();
        if (oa !== ea) begin bad++; $display("FAIL both_3x1_addr: got %0h want %0h", oa, ea); end
      end
    end
    while (exp_pulse.size() > 0) begin
      ep = exp_pulse.pop_front();
      total++;
      if (obs_pulse.size() == 0) begin bad++; $display("FAIL both_3x1_pulse: got none want %0h", ep); end
      else begin
        op = obs_pulse.pop_front();
        if (op !== ep) begin bad++; $display("FAIL both_3x1_pulse: got %0h want %0h", op, ep); end
      end
    end
    start_xfer(64'd1, 64'd1, 64'h30);
    exp_pulse.push_back({64'h130, 1'b1, 1'b1});
    repeat (10) @(negedge CLK);
    total++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 64'h30) begin
      bad++; $display("FAIL both_1x1_addr: got n=%0d a=%0h want 1 30", obs_addr.size(), obs_addr[0]);
    end
    ep = exp_pulse.pop_front();
    total++;
    if (obs_pulse.size() != 1 || obs_pulse[0] !== ep) begin
      bad++; $display("FAIL both_1x1_pulse: got n=%0d p=%0h want 1 %0h", obs_pulse.size(), obs_pulse[0], ep);
    end
    total++;
    if (READY !== 1'b1) begin bad++; $display("FAIL both_1x1_ready: got %b want 1", READY); end
    W_OUT_X_ENABLE = 1'b0; W_OUT_L_ENABLE = 1'b0;
  endtask

  task automatic test_zero_size();
    start_xfer(64'd0, 64'd3, 64'h50);
    for (int n = 0; n < 4; n++) begin
      total++;
      if (READY !== 1'b1) begin bad++; $display("FAIL zero_l_ready: got %b want 1", READY); end
      @(negedge CLK);
    end
    start_xfer(64'd2, 64'd0, 64'h50);
    repeat (4) @(negedge CLK);
    total++;
    if (obs_addr.size() != 0 || obs_pulse.size() != 0 || READY !== 1'b1) begin
      bad++; $display("FAIL zero_size: got reads=%0d pulses=%0d ready=%b want 0 0 1", obs_addr.size(), obs_pulse.size(), READY);
    end
  endtask

  task automatic test_abort_restart();
    bit ok;
    start_xfer(64'd4, 64'd4, 64'h40);
    wait_pulse(ok);
    answer(1'b0, 2);
    wait_pulse(ok);
    total++;
    if (!ok || W_IN !== 64'h141) begin bad++; $display("FAIL abort_second: got ok=%b w=%0h want 1 141", ok, W_IN); end
    #2 RST = 1'b1;
    #1;
    total++;
    if ({READY, MEMORY_READ, W_IN_L_ENABLE, W_IN_X_ENABLE} !== 4'b0 || W_IN !== '0 || MEMORY_ADDRESS !== '0) begin
      bad++; $display("FAIL abort_clear: got flags=%b w=%0h a=%0h want 0000 0 0",
                      {READY, MEMORY_READ, W_IN_L_ENABLE, W_IN_X_ENABLE}, W_IN, MEMORY_ADDRESS);
    end
    @(negedge CLK);
    RST = 1'b0;
    W_OUT_X_ENABLE = 1'b1; W_OUT_L_ENABLE = 1'b1;
    repeat (5) @(negedge CLK);
    W_OUT_X_ENABLE = 1'b0; W_OUT_L_ENABLE = 1'b0;
    total++;
    if (obs_addr.size() != 2 || obs_pulse.size() != 2) begin
      bad++; $display("FAIL abort_quiet: got reads=%0d pulses=%0d want 2 2", obs_addr.size(), obs_pulse.size());
    end
    start_xfer(64'd4, 64'd4, 64'h40);
    wait_pulse(ok);
    total++;
    if (!ok || W_IN !== 64'h140 || W_IN_L_ENABLE !== 1'b1 || obs_addr.size() != 1 || obs_addr[0] !== 64'h40) begin
      bad++; $display("FAIL abort_restart: got w=%0h l=%b a=%0h want 140 1 40", W_IN, W_IN_L_ENABLE, obs_addr[0]);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [DW-1:0] ea, oa;
    logic [DW+1:0] ep, op;
    start_xfer(64'd1, 64'd2, {DW{1'b1}});
    exp_addr.push_back({DW{1'b1}});
    exp_addr.push_back(64'h0);
    exp_pulse.push_back({64'hff, 1'b1, 1'b0});
    exp_pulse.push_back({64'h100, 1'b0, 1'b1});
    wait_pulse(ok);
    answer(1'b0, 2);
    wait_pulse(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout: got none want second pulse"); end
    repeat (3) @(negedge CLK);
    while (exp_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      total++;
      if (obs_addr.size() == 0) begin bad++; $display("FAIL wrap_addr: got none want %0h", ea); end
      else begin
        oa = obs_addr.pop_front();
        if (oa !== ea) begin bad++; $display("FAIL wrap_addr: got %0h want %0h", oa, ea); end
      end
    end
    while (exp_pulse.size() > 0) begin
      ep = exp_pulse.pop_front();
      total++;
      if (obs_pulse.size() == 0) begin bad++; $display("FAIL wrap_pulse: got none want %0h", ep); end
      else begin
        op = obs_pulse.pop_front();
        if (op !== ep) begin bad++; $display("FAIL wrap_pulse: got %0h want %0h", op, ep); end
      end
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; W_OUT_L_ENABLE = 1'b0; W_OUT_X_ENABLE = 1'b0;
    SIZE_L_IN = '0; SIZE_X_IN = '0; BASE_ADDRESS_IN = '0;
    test_reset();
    test_matrix_2x3();
    test_wrong_request();
    test_both_enables();
    test_zero_size();
    test_abort_restart();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
